polyphase_tx_commutator: RTL

// - Transmit-side counterpart of the polyphase decimator bank: a polyphase interpolator commutator.
// - Accepts one input sample per AXI-Stream beat and broadcasts it to N_PHASE external branch FIRs (fir_Tx_k).
// - Collects the N_PHASE branch results (unequal latency allowed) and serializes them phase 0..N_PHASE-1
//   on a backpressured output stream at N_PHASE x input rate.

---
 rtl/dc_pkg.sv | 15 +
 rtl/polyphase_tx_serializer.sv | 76 +++++++
 rtl/polyphase_tx_commutator.sv | 132 +++++++++++++
 3 files changed

// File: rtl/dc_pkg.sv
// Shared types and defaults for the polyphase commutator blocks.
package dc_pkg;

    localparam int unsigned N_PHASE_DEFAULT = 8;
    localparam int unsigned DATA_W_DEFAULT  = 32;

    typedef logic signed [DATA_W_DEFAULT-1:0] sample_t;
    typedef sample_t [N_PHASE_DEFAULT-1:0]     phase_bus_t;

    typedef enum logic [0:0] {
        ISSUE = 1'b0,
        WAIT  = 1'b1
    } tx_in_state_e;

endpackage

// File: rtl/polyphase_tx_serializer.sv
// Output bank plus phase counter: drains one loaded bank as N_PHASE AXI-Stream beats.
module polyphase_tx_serializer
    import dc_pkg::*;
#(
    parameter int unsigned N_PHASE = N_PHASE_DEFAULT,
    parameter int unsigned DATA_W  = DATA_W_DEFAULT
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [N_PHASE-1:0][DATA_W-1:0] bank,
    input  logic                           load_valid,
    output logic                           load_ready,
    output logic [DATA_W-1:0]              m_tdata,
    output logic                           m_tvalid,
    input  logic                           m_tready,
    output logic                           m_tlast
);

    localparam int unsigned     PH_W    = (N_PHASE > 1) ? $clog2(N_PHASE) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(N_PHASE - 1);

    logic [N_PHASE-1:0][DATA_W-1:0] bank_q, bank_d;
    logic [PH_W-1:0]                ph_q, ph_d;
    logic                           m_tvalid_q, m_tvalid_d;
    logic [DATA_W-1:0]              m_tdata_q, m_tdata_d;
    logic                           m_tlast_q, m_tlast_d;
    logic                           fire_c;

    // A new bank may land when empty or on the final beat, giving gapless back-to-back banks.
    always_comb begin
        bank_d     = bank_q;
        ph_d       = ph_q;
        m_tvalid_d = m_tvalid_q;
        fire_c     = m_tvalid_q && m_tready;
        load_ready = !m_tvalid_q || (fire_c && (ph_q == PH_LAST));

        if (fire_c) begin
            if (ph_q == PH_LAST) begin
                m_tvalid_d = 1'b0;
                ph_d       = '0;
            end else begin
                ph_d = ph_q + PH_W'(1);
            end
        end

        if (load_valid && load_ready) begin
            bank_d     = bank;
            m_tvalid_d = 1'b1;
            ph_d       = '0;
        end

        m_tdata_d = bank_d[ph_d];
        m_tlast_d = m_tvalid_d && (ph_d == PH_LAST);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bank_q     <= '0;
            ph_q       <= '0;
            m_tvalid_q <= 1'b0;
            m_tdata_q  <= '0;
            m_tlast_q  <= 1'b0;
        end else begin
            bank_q     <= bank_d;
            ph_q       <= ph_d;
            m_tvalid_q <= m_tvalid_d;
            m_tdata_q  <= m_tdata_d;
            m_tlast_q  <= m_tlast_d;
        end
    end

    assign m_tdata  = m_tdata_q;
    assign m_tvalid = m_tvalid_q;
    assign m_tlast  = m_tlast_q;

endmodule

// File: rtl/polyphase_tx_commutator.sv
// Polyphase interpolator commutator: broadcasts each input sample to the branch FIRs,
// gathers their results into a capture bank and hands full banks to the serializer.
module polyphase_tx_commutator
    import dc_pkg::*;
#(
    parameter int unsigned N_PHASE = N_PHASE_DEFAULT,
    parameter int unsigned DATA_W  = DATA_W_DEFAULT
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [DATA_W-1:0]              s_tdata,
    input  logic                           s_tvalid,
    output logic                           s_tready,
    output logic [N_PHASE-1:0][DATA_W-1:0] branch_input,
    output logic [N_PHASE-1:0]             branch_input_tvalid,
    input  logic [N_PHASE-1:0][DATA_W-1:0] branch_output,
    input  logic [N_PHASE-1:0]             branch_output_tvalid,
    output logic [DATA_W-1:0]              m_tdata,
    output logic                           m_tvalid,
    input  logic                           m_tready,
    output logic                           m_tlast,
    output logic                           overrun
);

    localparam logic [0:0] ST_ISSUE = 1'(ISSUE);
    localparam logic [0:0] ST_WAIT  = 1'(WAIT);

    logic [0:0]                     state_q, state_d;
    logic                           s_tready_q, s_tready_d;
    logic [N_PHASE-1:0][DATA_W-1:0] bin_q, bin_d;
    logic [N_PHASE-1:0]             bin_tvalid_q, bin_tvalid_d;
    logic [N_PHASE-1:0]             mask_q, mask_d;
    logic [N_PHASE-1:0][DATA_W-1:0] cap_bank_q, cap_bank_d;
    logic                           overrun_q, overrun_d;
    logic                           issued_q, issued_d;
    logic [N_PHASE-1:0]             new_c, dup_c;
    logic                           accept_c, load_valid_c, load_ready_c;

    // cap_bank_d already merges this cycle's arrivals, so it doubles as the load bus.
    always_comb begin
        state_d      = state_q;
        bin_d        = bin_q;
        bin_tvalid_d = '0;
        mask_d       = mask_q;
        cap_bank_d   = cap_bank_q;
        overrun_d    = overrun_q;
        issued_d     = issued_q;
        new_c        = '0;
        dup_c        = '0;
        load_valid_c = 1'b0;
        accept_c     = (state_q == ST_ISSUE) && s_tvalid && s_tready_q;

        if (state_q == ST_ISSUE) begin
            // Stray results before the first issue (e.g. left over from before reset) are ignored.
            if (issued_q && (|branch_output_tvalid)) begin
                overrun_d = 1'b1;
            end
            if (accept_c) begin
                for (int unsigned k = 0; k < N_PHASE; k++) begin
                    bin_d[k] = s_tdata;
                end
                bin_tvalid_d = '1;
                issued_d     = 1'b1;
                state_d      = ST_WAIT;
            end
        end else begin
            new_c = branch_output_tvalid & ~mask_q;
            dup_c = branch_output_tvalid & mask_q;
            if (|dup_c) begin
                overrun_d = 1'b1;
            end
            for (int unsigned k = 0; k < N_PHASE; k++) begin
                if (new_c[k]) begin
                    cap_bank_d[k] = branch_output[k];
                end
            end
            mask_d = mask_q | new_c;
            if (&mask_d) begin
                load_valid_c = 1'b1;
                if (load_ready_c) begin
                    mask_d  = '0;
                    state_d = ST_ISSUE;
                end
            end
        end

        s_tready_d = (state_d == ST_ISSUE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_ISSUE;
            s_tready_q   <= 1'b0;
            bin_q        <= '0;
            bin_tvalid_q <= '0;
            mask_q       <= '0;
            cap_bank_q   <= '0;
            overrun_q    <= 1'b0;
            issued_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            s_tready_q   <= s_tready_d;
            bin_q        <= bin_d;
            bin_tvalid_q <= bin_tvalid_d;
            mask_q       <= mask_d;
            cap_bank_q   <= cap_bank_d;
            overrun_q    <= overrun_d;
            issued_q     <= issued_d;
        end
    end

    polyphase_tx_serializer #(
        .N_PHASE (N_PHASE),
        .DATA_W  (DATA_W)
    ) u_serializer (
        .clk        (clk),
        .rstn       (rstn),
        .bank       (cap_bank_d),
        .load_valid (load_valid_c),
        .load_ready (load_ready_c),
        .m_tdata    (m_tdata),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tlast    (m_tlast)
    );

    assign s_tready            = s_tready_q;
    assign branch_input        = bin_q;
    assign branch_input_tvalid = bin_tvalid_q;
    assign overrun             = overrun_q;

endmodule
